// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pdm_pkg
// Purpose : Definitions shared by the PDM receive path and the tests on the
//           modulator side. It holds the default value width, the state
//           encodings and the saturating scale function.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package pdm_pkg;

  localparam int PDM_VALUE_BITS = 8;

  // State encodings for the demodulator controller
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  // Scales a window's ones-count up to value_bits. A window made entirely of
  // ones counts 2^window_log2, which does not fit after scaling, so it
  // clamps to full scale. Widths are capped at 31 bits.
  function automatic logic [31:0] sat_scale(input logic [31:0] total,
                                            input int value_bits,
                                            input int window_log2);
    logic [31:0] full;
    full = 32'd1 << window_log2;
    if (total == full) begin
      sat_scale = (32'd1 << value_bits) - 32'd1;
    end else begin
      sat_scale = total << (value_bits - window_log2);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_window_counter.sv
`default_nettype none
// ============================================================================
// Module  : pdm_window_counter
// Purpose : Counts ones over a window of 2^WINDOW_LOG2 accepted samples.
//           It pulses window_end on the cycle that takes the last sample of a
//           window. On that cycle, total holds the complete count including
//           the current sample.
// Ports   : clk, reset      clock, synchronous active-high reset
//           clear           discard the partial window (count/phase -> 0)
//           step            accept bit_in this cycle
//           bit_in          bitstream sample
//           window_end      last sample of a window is being taken
//           total           count + bit_in (WINDOW_LOG2+1 bits)
// Rev     : 1.0  initial release
// ============================================================================
module pdm_window_counter #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 bit_in,
  output logic                 window_end,
  output logic [WINDOW_LOG2:0] total
);

  // The count never exceeds 2^WINDOW_LOG2-1 before the last sample, so it
  // fits in WINDOW_LOG2 bits. Only the combined total needs the extra bit.
  logic [WINDOW_LOG2-1:0] count;
  logic [WINDOW_LOG2-1:0] phase;

  assign window_end = step && (phase == '1);
  assign total      = {1'b0, count} + (WINDOW_LOG2+1)'(bit_in);

  always_ff @(posedge clk) begin
    if (reset || clear || window_end) begin
      count <= '0;
      phase <= '0;
    end else if (step) begin
      count <= count + WINDOW_LOG2'(bit_in);
      phase <= phase + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdm_demod.sv
`default_nettype none
// ============================================================================
// Module  : pdm_demod
// Purpose : Boxcar decimator for a 1-bit PDM stream. It counts the ones over
//           2^WINDOW_LOG2 samples and presents one scaled, saturated value per
//           window on a valid/ready interface. A sticky overrun flag records
//           a result that was overwritten before it was consumed.
// Params  : VALUE_BITS (<=31), WINDOW_LOG2 in 1..VALUE_BITS
// Config  : PDM_DEMOD_SYNC_EN - when defined, the input passes through a
//           2-flop synchronizer and results arrive 2 clk later.
// Ports   : clk, reset          clock, synchronous active-high reset
//           sample_en, pdm_in   sample strobe and bitstream
//           enable              1 = accumulate, 0 = abort window / idle
//           value_out, valid    result and its valid flag
//           ready               consumer accept
//           overrun             sticky lost-result flag
// Rev     : 1.0  initial release
// ============================================================================
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int VALUE_BITS  = PDM_VALUE_BITS,
  parameter int WINDOW_LOG2 = VALUE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic                  pdm_in,
  input  logic                  enable,
  output logic [VALUE_BITS-1:0] value_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun
);

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM
  } state_t;

  logic                 bit_s;
  logic                 strobe_s;
  logic                 enable_s;
  state_t               state;
  state_t               state_next;
  logic                 clear;
  logic                 step;
  logic                 window_end;
  logic [WINDOW_LOG2:0] total;
  logic [VALUE_BITS-1:0] scaled;

`ifdef PDM_DEMOD_SYNC_EN
  // The bit is synchronized on every clk. The strobe and enable go through
  // the same two stages, so each synchronized bit stays paired with its own
  // strobe. Every window then keeps its sample alignment and only moves
  // later by 2 clk.
  logic [1:0] pdm_sync;
  logic [1:0] strobe_dly;
  logic [1:0] enable_dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      pdm_sync   <= '0;
      strobe_dly <= '0;
      enable_dly <= '0;
    end else begin
      pdm_sync   <= {pdm_sync[0], pdm_in};
      strobe_dly <= {strobe_dly[0], sample_en};
      enable_dly <= {enable_dly[0], enable};
    end
  end

  assign bit_s    = pdm_sync[1];
  assign strobe_s = strobe_dly[1];
  assign enable_s = enable_dly[1];
`else
  assign bit_s    = pdm_in;
  assign strobe_s = sample_en;
  assign enable_s = enable;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The sample that arrives with enable is already counted. Enable low
  // clears the window, both when leaving ACCUM (the partial window is lost)
  // and while in IDLE (count and phase stay at 0).
  always_comb begin
    state_next = state;
    clear      = !enable_s;
    step       = enable_s && strobe_s;
    case (state)
      IDLE:    if (enable_s)  state_next = ACCUM;
      ACCUM:   if (!enable_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  pdm_window_counter #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .step       (step),
    .bit_in     (bit_s),
    .window_end (window_end),
    .total      (total)
  );

  assign scaled = VALUE_BITS'(sat_scale(32'(total), VALUE_BITS, WINDOW_LOG2));

  // A new result always loads. It counts as an overrun only when the
  // previous one is still pending and is not being accepted this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_out <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else if (window_end) begin
      value_out <= scaled;
      valid     <= 1'b1;
      if (valid && !ready) overrun <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
